// File: rtl/stopwatch_display.sv
// stopwatch_display: six-digit multiplexed 7-segment driver for the stopwatch fields.
// Page 0 shows hh mm ss and page 1 shows yy mm dd. The selected fields are
// snapshotted at each frame boundary and converted to BCD by repeated subtraction.
// The result is shown from the following frame boundary, so digits never change
// mid-frame. Optional build macro PAGE_DEBOUNCE_EN debounces page_btn over
// DEB_CYCLES clocks; without it the synchronized level is used directly.
module stopwatch_display #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] second,
    input  logic [5:0] minute,
    input  logic [4:0] hour,
    input  logic [4:0] day,
    input  logic [3:0] month,
    input  logic [6:0] year,
    input  logic       page_btn,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       page
);
    localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DASH     = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

    generate
        if (SCAN_DIV < 64 || SCAN_DIV > 65535 || DEB_CYCLES < 1) begin : g_param_check
            $error("stopwatch_display: SCAN_DIV or DEB_CYCLES out of range");
        end
    endgenerate

    // ---------------- scan timing ----------------
    logic [15:0] cnt_reg;
    logic [2:0]  idx_reg;
    logic        frame_tick;

    assign frame_tick = (cnt_reg == SCAN_MAX) && (idx_reg == 3'd5);

    // Slot counter and digit index; a frame is six slots of SCAN_DIV clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else if (cnt_reg == SCAN_MAX) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    // ---------------- page button ----------------
    logic sync1_reg, sync2_reg;
    logic level;
    logic level_prev_reg;
    logic page_pend_reg;
    logic page_reg;

    // Two-flop synchronizer for the asynchronous push-button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= page_btn;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef PAGE_DEBOUNCE_EN
    localparam int               DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             deb_level_reg;

    // Accept a new level only once it has differed for DEB_CYCLES straight clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt_reg   <= '0;
            deb_level_reg <= 1'b0;
        end else if (sync2_reg == deb_level_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_MAX) begin
            deb_level_reg <= sync2_reg;
            deb_cnt_reg   <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end

    assign level = deb_level_reg;
`else
    assign level = sync2_reg;
`endif

    // Press toggles the pending page; the visible page follows at a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_prev_reg <= 1'b0;
            page_pend_reg  <= 1'b0;
            page_reg       <= 1'b0;
        end else begin
            level_prev_reg <= level;
            if (level && !level_prev_reg) begin
                page_pend_reg <= ~page_pend_reg;
            end
            if (frame_tick) begin
                page_reg <= page_pend_reg;
            end
        end
    end

    assign page = page_reg;

    // ---------------- field selection ----------------
    // Field 0 is the rightmost pair, field 2 the leftmost
    logic [6:0] time_f [3];
    logic [6:0] date_f [3];
    logic [6:0] sel_f  [3];

    assign time_f[0] = {1'b0, second};
    assign time_f[1] = {1'b0, minute};
    assign time_f[2] = {2'b0, hour};
    assign date_f[0] = {2'b0, day};
    assign date_f[1] = {3'b0, month};
    assign date_f[2] = year;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sel
            assign sel_f[gi] = page_pend_reg ? date_f[gi] : time_f[gi];
        end
    endgenerate

    // ---------------- binary to BCD conversion ----------------
    state_t     state_reg;
    logic [1:0] fld_reg;
    logic [6:0] work_reg;
    logic [3:0] tens_reg;
    logic [6:0] snap_reg [3];
    logic [7:0] conv_reg [3];
    logic [7:0] pend_reg [3];
    logic [7:0] disp_reg [3];

    // Snapshot at each boundary, then subtract 10 per clock, one field after another
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            fld_reg   <= '0;
            work_reg  <= '0;
            tens_reg  <= '0;
            for (int i = 0; i < 3; i++) begin
                snap_reg[i] <= '0;
                conv_reg[i] <= '0;
                pend_reg[i] <= '0;
            end
        end else if (frame_tick) begin
            // A boundary always (re)starts conversion, aborting any unfinished one
            for (int i = 0; i < 3; i++) begin
                snap_reg[i] <= sel_f[i];
            end
            state_reg <= LOAD;
        end else begin
            case (state_reg)
                LOAD: begin
                    fld_reg   <= 2'd0;
                    work_reg  <= snap_reg[0];
                    tens_reg  <= '0;
                    state_reg <= CONV;
                end
                CONV: begin
                    if (work_reg >= 7'd10 && work_reg <= 7'd99) begin
                        work_reg <= work_reg - 7'd10;
                        tens_reg <= tens_reg + 4'd1;
                    end else begin
                        // Values above 99 cannot be shown as two digits: show dashes
                        conv_reg[fld_reg] <= (work_reg > 7'd99) ? {DASH, DASH}
                                                                : {tens_reg, work_reg[3:0]};
                        if (fld_reg == 2'd2) begin
                            state_reg <= DONE;
                        end else begin
                            fld_reg  <= fld_reg + 2'd1;
                            work_reg <= snap_reg[fld_reg + 2'd1];
                            tens_reg <= '0;
                        end
                    end
                end
                DONE: begin
                    for (int i = 0; i < 3; i++) begin
                        pend_reg[i] <= conv_reg[i];
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Display digits only change at a frame boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                disp_reg[i] <= '0;
            end
        end else if (frame_tick) begin
            for (int i = 0; i < 3; i++) begin
                disp_reg[i] <= pend_reg[i];
            end
        end
    end

    // ---------------- output stage ----------------
    logic [7:0] cur_pair;
    logic [3:0] cur_digit;
    logic [6:0] seg_next;

    // Pick the digit for the current slot and encode it (active-low {g,f,e,d,c,b,a})
    always_comb begin
        cur_pair  = disp_reg[idx_reg[2:1]];
        cur_digit = idx_reg[0] ? cur_pair[7:4] : cur_pair[3:0];
        seg_next  = 7'b1111111;
        case (cur_digit)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            DASH:    seg_next = 7'b0111111;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Registered digit enable, segments and decimal points (dp after hours and minutes)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 6'b111111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(6'd1 << idx_reg);
            seg <= seg_next;
            dp  <= !(idx_reg == 3'd2 || idx_reg == 3'd4);
        end
    end

endmodule
